uart_byte_receiver: RTL and testbench

- 8N1 asynchronous serial receiver: LSB first, no parity, one stop bit.
- Reconstructs bytes from the rs232_rx line using 16x oversampling and a majority vote on the centre of each bit.
- Emits each byte with a one-clock rx_done strobe.
- Sits behind the board RX pin and feeds the command/data parser.
- Paired with the byte transmitter in loopback tests.

---
 rtl/uart_byte_receiver.sv | 176 +++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   8N1 serial receiver (LSB first, no parity, one stop bit) using 16x
//   oversampling with a 7-sample majority vote around the centre of each bit.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz; all baud divisors derive from it.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   baud_set  rate select: 0=9600, 1=19200, 2=38400, 3=115200
//   rs232_rx  serial line, asynchronous to clk, idle high
//   rx_byte   last received byte, held until the next byte completes
//   rx_done   one-clock pulse when rx_byte is updated
//   frame_err one-clock pulse on a stop-bit vote of 0 (only when
//             UART_RX_FRAME_ERR_EN is defined; the byte is then dropped)
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
module uart_byte_receiver #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] rx_byte,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic       rx_done
);

  localparam int DIV_9600   = CLK_FREQ / (9600 * 16);
  localparam int DIV_19200  = CLK_FREQ / (19200 * 16);
  localparam int DIV_38400  = CLK_FREQ / (38400 * 16);
  localparam int DIV_115200 = CLK_FREQ / (115200 * 16);
  // The slowest rate has the largest divisor; size the counter for it.
  localparam int CW = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg, state_next;
  logic           rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  logic [1:0]     baud_reg;
  logic [CW-1:0]  baud_cnt_reg;
  logic [CW-1:0]  div_m1;
  logic [7:0]     tick_cnt_reg;
  logic [7:0]     cur_idx;
  logic [3:0]     sub_idx;
  logic [3:0]     bit_idx;
  logic [2:0]     vote_sum_reg;
  logic           vote;
  logic [7:0]     shift_reg;
  logic [7:0]     rx_byte_reg;
  logic           rx_done_reg;
  logic           fall;
  logic           tick;
  logic           frame_end;
`ifdef UART_RX_FRAME_ERR_EN
  logic           frame_err_reg;
`endif

  assign fall = rx_prev_reg & ~rx_sync2_reg;

  always_comb begin
    div_m1 = CW'(DIV_9600 - 1);
    case (baud_reg)
      2'd0: div_m1 = CW'(DIV_9600 - 1);
      2'd1: div_m1 = CW'(DIV_19200 - 1);
      2'd2: div_m1 = CW'(DIV_38400 - 1);
      2'd3: div_m1 = CW'(DIV_115200 - 1);
    endcase
  end

  assign tick = (state_reg == RUN) && (baud_cnt_reg == div_m1);

  // tick_cnt_reg counts ticks already seen, so the tick happening now has
  // index tick_cnt_reg+1: tick k then falls k*DIV clocks after the edge.
  assign cur_idx = tick_cnt_reg + 8'd1;
  assign sub_idx = cur_idx[3:0];
  assign bit_idx = cur_idx[7:4];
  // Sum of 7 samples is at least 4 exactly when its MSB is set.
  assign vote    = vote_sum_reg[2];

  always_comb begin
    state_next = state_reg;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall) state_next = RUN;
      end
      RUN: begin
        if (tick && sub_idx == 4'd13) begin
          if (bit_idx == 4'd0 && vote) begin
            state_next = IDLE;            // glitch: start bit read high
          end else if (bit_idx == 4'd9) begin
            state_next = IDLE;            // early re-arm for back-to-back
            frame_end  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_reg  <= 1'b1;
      rx_sync2_reg  <= 1'b1;
      rx_prev_reg   <= 1'b1;
      baud_reg      <= 2'd0;
      baud_cnt_reg  <= '0;
      tick_cnt_reg  <= 8'd0;
      vote_sum_reg  <= 3'd0;
      shift_reg     <= 8'd0;
      rx_byte_reg   <= 8'd0;
      rx_done_reg   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
    end else begin
      rx_sync1_reg  <= rs232_rx;
      rx_sync2_reg  <= rx_sync1_reg;
      rx_prev_reg   <= rx_sync2_reg;
      rx_done_reg   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
      if (state_reg == IDLE) begin
        baud_cnt_reg <= '0;
        tick_cnt_reg <= 8'd0;
        vote_sum_reg <= 3'd0;
        if (fall) baud_reg <= baud_set;   // rate frozen for the whole frame
      end else if (tick) begin
        baud_cnt_reg <= '0;
        tick_cnt_reg <= cur_idx;
        if (sub_idx >= 4'd6 && sub_idx <= 4'd12) begin
          vote_sum_reg <= vote_sum_reg + {2'b00, rx_sync2_reg};
        end else if (sub_idx == 4'd13) begin
          vote_sum_reg <= 3'd0;
          if (bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
            shift_reg <= {vote, shift_reg[7:1]};   // LSB arrives first
          end
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end

      if (frame_end) begin
`ifdef UART_RX_FRAME_ERR_EN
        if (vote) begin
          rx_byte_reg <= shift_reg;
          rx_done_reg <= 1'b1;
        end else begin
          frame_err_reg <= 1'b1;
        end
`else
        rx_byte_reg <= shift_reg;
        rx_done_reg <= 1'b1;
`endif
      end
    end
  end

  assign rx_byte = rx_byte_reg;
  assign rx_done = rx_done_reg;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Testbench for uart_byte_receiver. Frames are driven clock by clock from a
// bit table; expected bytes come from a majority-vote model of the line as
// the bench drove it, and one monitor compares every cycle.
module tb_uart_byte_receiver;

  localparam int CLK_FREQ = 3_686_400;   // divisors 24 / 12 / 6 / 2

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baud_set = 2'd0;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_count = 0;
  int last_latency = 0;

  typedef struct {
    logic [7:0] data;
    int         fall_cyc;
    int         div;
    bit         is_err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] hold_val = 8'h00;

  uart_byte_receiver #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_set (baud_set),
    .rs232_rx (rs232_rx),
    .rx_byte  (rx_byte),
`ifdef UART_RX_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .rx_done  (rx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int div_of(input int rate);
    int baud;
    case (rate)
      0: baud = 9600;
      1: baud = 19200;
      2: baud = 38400;
      default: baud = 115200;
    endcase
    return CLK_FREQ / (baud * 16);
  endfunction

  // Samples at sub-ticks 6..12 of bit b; the noise window inverts the line
  // for sub-ticks ns and ns+1 of bit nb. Value is 1 when >= 4 samples are 1.
  function automatic logic bit_vote(input logic v, input int b, input int nb, input int ns);
    int sum = 0;
    for (int s = 6; s <= 12; s++) begin
      if ((v ^ (b == nb && (s == ns || s == ns + 1))) == 1'b1) sum++;
    end
    return (sum >= 4);
  endfunction

  // Monitor: one compare process for every cycle outside reset.
  always @(negedge clk) begin
    logic ev_err;
    exp_t e;
    ev_err = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ev_err = frame_err;
`endif
    if (rst) begin
      hold_val = 8'h00;
    end else if (rx_done || ev_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, rx_done, ev_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {30'd0, rx_done, ev_err}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) begin
          check("rx_byte", rx_byte, e.data);
          hold_val = e.data;
        end else begin
          check("rx_byte_kept_on_err", rx_byte, hold_val);
        end
        last_latency = cyc - e.fall_cyc;
        check_range("latency", last_latency, 157 * e.div + 3, 157 * e.div + 5);
      end
      if (rx_done) done_count++;
    end else begin
      check("rx_byte_hold", rx_byte, hold_val);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rs232_rx = 1'b1;
    end
  endtask

  // Drives one frame; chg_at/abort_at are clock offsets (-1 = never).
  task automatic send_frame(input logic [7:0] d, input int rate, input int nb, input int ns,
                            input logic stop, input int chg_at, input int chg_rate,
                            input int abort_at);
    int div;
    int b;
    logic v;
    logic stop_v;
    logic [9:0] fb;
    exp_t e;
    div = div_of(rate);
    fb  = {stop, d, 1'b0};
    for (int k = 1; k <= 8; k++) e.data[k-1] = bit_vote(fb[k], k, nb, ns);
    stop_v = bit_vote(fb[9], 9, nb, ns);
    e.div = div;
`ifdef UART_RX_FRAME_ERR_EN
    e.is_err = !stop_v;
`else
    e.is_err = 1'b0;
    if (stop_v) e.is_err = 1'b0;
`endif
    for (int c = 0; c < 160 * div; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        baud_set   = rate[1:0];
        e.fall_cyc = cyc;
        if (abort_at < 0) exp_q.push_back(e);
      end
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_rx_byte", rx_byte, 8'h00);
        rs232_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (c == chg_at) baud_set = chg_rate[1:0];
      b = c / (16 * div);
      v = fb[b];
      if (b == nb && c >= (16 * b + ns) * div && c < (16 * b + ns + 2) * div) v = ~v;
      rs232_rx = v;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int dc;
    int rate;
    int nb;
    int ns;
    logic [7:0] d;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Loopback-style frames at rate 1
    send_frame(8'hAA, 1, -1, 0, 1'b1, -1, 0, -1);
    idle(20);
    wait_drain(4000);
    check("aa_literal", rx_byte, 8'hAA);
    check_range("aa_latency_literal", last_latency, 1887, 1889);
    send_frame(8'h55, 1, -1, 0, 1'b1, -1, 0, -1);
    idle(20);
    wait_drain(4000);
    check("55_literal", rx_byte, 8'h55);

    // Back-to-back, zero idle gap, at 115200
    dc = done_count;
    send_frame(8'h00, 3, -1, 0, 1'b1, -1, 0, -1);
    send_frame(8'hFF, 3, -1, 0, 1'b1, -1, 0, -1);
    idle(20);
    wait_drain(4000);
    check("b2b_count", done_count - dc, 2);
    check("b2b_last_literal", rx_byte, 8'hFF);

    // Glitch rejection at 9600
    dc = done_count;
    baud_set = 2'd0;
    repeat (3) begin
      @(posedge clk); #1;
      rs232_rx = 1'b0;
    end
    idle(20 * 24);
    check("glitch_no_done", done_count - dc, 0);
    check("glitch_byte_kept", rx_byte, 8'hFF);

    // Noise: D3 (bit 4) sub-ticks 6 and 7 inverted
    send_frame(8'hA5, 2, 4, 6, 1'b1, -1, 0, -1);
    idle(20);
    wait_drain(4000);
    check("noise_literal", rx_byte, 8'hA5);

    // Rate sweep
    for (int r = 0; r < 4; r++) begin
      send_frame(8'h3C, r, -1, 0, 1'b1, -1, 0, -1);
      idle(10);
      wait_drain(4000);
      check("sweep_literal", rx_byte, 8'h3C);
    end

    // baud_set changed mid-frame
    send_frame(8'h96, 2, -1, 0, 1'b1, 60 * 6, 0, -1);
    idle(20);
    wait_drain(4000);
    check("midchange_literal", rx_byte, 8'h96);

    // Stop bit forced low
    send_frame(8'h5A, 3, -1, 0, 1'b0, -1, 0, -1);
    idle(40);
    wait_drain(4000);
`ifdef UART_RX_FRAME_ERR_EN
    check("stop0_byte_kept", rx_byte, 8'h96);
`else
    check("stop0_delivered", rx_byte, 8'h5A);
`endif

    // Reset during D4, then a clean frame
    send_frame(8'h77, 2, -1, 0, 1'b1, -1, 0, (16 * 5 + 8) * 6);
    idle(40);
    check("after_rst_byte", rx_byte, 8'h00);
    send_frame(8'h81, 2, -1, 0, 1'b1, -1, 0, -1);
    idle(20);
    wait_drain(4000);
    check("post_rst_literal", rx_byte, 8'h81);

    // Randomized frames with optional two-sub-tick noise bursts
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      rate = int'($urandom_range(1, 3));
      nb   = -1;
      ns   = 0;
      if ($urandom_range(0, 1) == 1) begin
        nb = int'($urandom_range(1, 9));
        ns = int'($urandom_range(2, 12));
      end
      send_frame(d, rate, nb, ns, 1'b1, -1, 0, -1);
      idle(int'($urandom_range(0, 15)));
    end
    idle(20);
    wait_drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
